controlador_estados: RTL

- Pet behaviour FSM. Produces the 5-bit `estado` code that `controlador_atributos` consumes, and reads back its `fome`/`felicidade`/`sono` outputs. It closes the loop between player buttons, the attribute controller and the display.
- Decides intro, idle, activity (sleep/eat/teach), and death. Activity length is bounded by a timer and by the attribute saturating.

---
 rtl/tamagotchi_pkg.sv | 32 +++
 rtl/controlador_estados_if.sv | 24 ++
 rtl/detector_borda.sv | 27 ++
 rtl/controlador_estados.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared definitions for the pet controllers: state codes, attribute limits and widths.
// Imported by controlador_estados, its sub-modules and controlador_atributos.
package tamagotchi_pkg;

  localparam int unsigned LARGURA_ESTADO   = 5;
  localparam int unsigned LARGURA_ATRIBUTO = 8;

  localparam logic [LARGURA_ESTADO-1:0] INTRO      = 5'b00000;
  localparam logic [LARGURA_ESTADO-1:0] IDLE       = 5'b00001;
  localparam logic [LARGURA_ESTADO-1:0] DORMINDO   = 5'b00010;
  localparam logic [LARGURA_ESTADO-1:0] COMENDO    = 5'b00100;
  localparam logic [LARGURA_ESTADO-1:0] DANDO_AULA = 5'b01000;
  localparam logic [LARGURA_ESTADO-1:0] MORTO      = 5'b10000;

  localparam logic [LARGURA_ATRIBUTO-1:0] MAX_ATRIBUTO = 8'd100;

  typedef enum logic [LARGURA_ESTADO-1:0] {
    StIntro     = INTRO,
    StIdle      = IDLE,
    StDormindo  = DORMINDO,
    StComendo   = COMENDO,
    StDandoAula = DANDO_AULA,
    StMorto     = MORTO
  } estado_e;

  function automatic logic morreu(input logic [LARGURA_ATRIBUTO-1:0] fome,
                                  input logic [LARGURA_ATRIBUTO-1:0] felicidade,
                                  input logic [LARGURA_ATRIBUTO-1:0] sono);
    return (fome == '0) || (felicidade == '0) || (sono == '0);
  endfunction

endpackage

// File: rtl/controlador_estados_if.sv
// Button/attribute/state bundle between the player side and the behaviour FSM.
interface controlador_estados_if;
  import tamagotchi_pkg::*;

  logic                        btn_start;
  logic                        btn_dormir;
  logic                        btn_comer;
  logic                        btn_aula;
  logic [LARGURA_ATRIBUTO-1:0] fome;
  logic [LARGURA_ATRIBUTO-1:0] felicidade;
  logic [LARGURA_ATRIBUTO-1:0] sono;
  logic [LARGURA_ESTADO-1:0]   estado;

  modport master (
    output btn_start, btn_dormir, btn_comer, btn_aula, fome, felicidade, sono,
    input  estado
  );

  modport slave (
    input  btn_start, btn_dormir, btn_comer, btn_aula, fome, felicidade, sono,
    output estado
  );

endinterface

// File: rtl/detector_borda.sv
// Two-flop synchroniser for an asynchronous level input plus a one-cycle rising-edge pulse.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/controlador_estados.sv
// Pet behaviour FSM: intro, idle, timed activities (sleep/eat/teach) and death.
// Optional macro AUTO_DORMIR_EN: idle pet falls asleep when sono drops below LIMIAR_SONO.
module controlador_estados
  import tamagotchi_pkg::*;
#(
  parameter logic [31:0]                 DURACAO      = 32'd50_000_000,
  parameter logic [LARGURA_ATRIBUTO-1:0] MAX_ATRIBUTO = tamagotchi_pkg::MAX_ATRIBUTO,
  parameter logic [LARGURA_ATRIBUTO-1:0] LIMIAR_SONO  = 8'd20
) (
  input logic                  clk,
  input logic                  rst_n,
  controlador_estados_if.slave bus
);

  estado_e     r_estado;
  logic [31:0] r_timer;

  logic w_p_start;
  logic w_p_dormir;
  logic w_p_comer;
  logic w_p_aula;
  logic w_morreu;
  logic w_cancela;
  logic w_saturou;
  logic w_sono_baixo;
  logic w_auto_dormir;

  detector_borda u_borda_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_start),
    .o_pulse(w_p_start)
  );

  detector_borda u_borda_dormir (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_dormir),
    .o_pulse(w_p_dormir)
  );

  detector_borda u_borda_comer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_comer),
    .o_pulse(w_p_comer)
  );

  detector_borda u_borda_aula (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_aula),
    .o_pulse(w_p_aula)
  );

  assign w_morreu     = morreu(bus.fome, bus.felicidade, bus.sono);
  assign w_sono_baixo = bus.sono < LIMIAR_SONO;

`ifdef AUTO_DORMIR_EN
  assign w_auto_dormir = w_sono_baixo & ~(w_p_start | w_p_dormir | w_p_comer | w_p_aula);
`else
  // Feature off: auto-sleep can never fire.
  assign w_auto_dormir = w_sono_baixo & 1'b0;
`endif

  // Each activity is cancelled by its own button and ends when its own attribute saturates.
  always_comb begin
    w_cancela = 1'b0;
    w_saturou = 1'b0;
    case (r_estado)
      StDormindo: begin
        w_cancela = w_p_dormir;
        w_saturou = (bus.sono == MAX_ATRIBUTO);
      end
      StComendo: begin
        w_cancela = w_p_comer;
        w_saturou = (bus.fome == MAX_ATRIBUTO);
      end
      StDandoAula: begin
        w_cancela = w_p_aula;
        w_saturou = (bus.felicidade == MAX_ATRIBUTO);
      end
      default: begin
        w_cancela = 1'b0;
        w_saturou = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= StIntro;
      r_timer  <= '0;
    end else begin
      case (r_estado)
        StIntro: begin
          r_timer <= '0;
          if (w_p_start) r_estado <= StIdle;
        end
        StIdle: begin
          r_timer <= '0;
          if (w_morreu) begin
            r_estado <= StMorto;
          end else if (w_p_dormir) begin
            r_estado <= StDormindo;
            r_timer  <= DURACAO - 32'd1;
          end else if (w_p_comer) begin
            r_estado <= StComendo;
            r_timer  <= DURACAO - 32'd1;
          end else if (w_p_aula) begin
            r_estado <= StDandoAula;
            r_timer  <= DURACAO - 32'd1;
          end else if (w_auto_dormir) begin
            r_estado <= StDormindo;
            r_timer  <= DURACAO - 32'd1;
          end
        end
        StDormindo, StComendo, StDandoAula: begin
          if (w_morreu) begin
            r_estado <= StMorto;
            r_timer  <= '0;
          end else if (w_cancela || w_saturou || (r_timer == '0)) begin
            r_estado <= StIdle;
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        StMorto: begin
          r_timer <= '0;
          if (w_p_start) r_estado <= StIntro;
        end
        default: begin
          r_estado <= StIntro;
          r_timer  <= '0;
        end
      endcase
    end
  end

  assign bus.estado = r_estado;

endmodule
